// File: rtl/dcache_2way_wb_if.sv
// CPU-side request/stall signals and block-wide memory handshake of dcache_2way_wb.
// The cache connects through the slave modport; the CPU/memory environment uses master.
interface dcache_2way_wb_if #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int BLOCK_WORDS = 4
);
  localparam int OFFSET_W = $clog2(BLOCK_WORDS);
  localparam int BLOCK_W  = DATA_W * BLOCK_WORDS;

  logic                         read;
  logic                         write;
  logic [ADDR_W-1:0]            address;
  logic [DATA_W-1:0]            writedata;
  logic [DATA_W-1:0]            readdata;
  logic                         busywait;
  logic                         mem_read;
  logic                         mem_write;
  logic [ADDR_W-OFFSET_W-1:0]   mem_address;
  logic [BLOCK_W-1:0]           mem_writedata;
  logic [BLOCK_W-1:0]           mem_readdata;
  logic                         mem_busywait;

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_2way_wb.sv
// 2-way set-associative write-back, write-allocate data cache with LRU replacement
// and saturating first-lookup hit / miss counters.
module dcache_2way_wb #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int SETS        = 4,
  parameter int COUNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  dcache_2way_wb_if.slave    bus,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count
);
  localparam int OFFSET_W = $clog2(BLOCK_WORDS);
  localparam int INDEX_W  = $clog2(SETS);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int BLOCK_W  = DATA_W * BLOCK_WORDS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_nxt;

  logic [BLOCK_W-1:0] data_mem [2][SETS];
  logic [TAG_W-1:0]   tag_mem  [2][SETS];
  logic [1:0]         valid    [SETS];
  logic [1:0]         dirty    [SETS];
  logic [SETS-1:0]    lru;           // way to evict next in each set

  logic               victim_way;
  logic               first_cycle;   // first cycle spent in WRITEBACK/ALLOCATE
  logic               retry;         // lookup right after a fill, not counted as a hit

  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] idx;
  logic [OFFSET_W-1:0] off;
  logic               request;
  logic [1:0]         way_match;
  logic               hit;
  logic               hit_way;
  logic               victim_sel;
  logic               mem_done;

  assign {tag, idx, off} = bus.address;
  assign request = bus.read ^ bus.write;

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      way_match[w] = valid[idx][w] && (tag_mem[w][idx] == tag);
    end
  end

  assign hit        = request && (|way_match);
  assign hit_way    = way_match[1];
  assign victim_sel = !valid[idx][0] ? 1'b0 : (!valid[idx][1] ? 1'b1 : lru[idx]);
  assign mem_done   = !first_cycle && !bus.mem_busywait;

  assign bus.readdata = (hit && bus.read) ? data_mem[hit_way][idx][int'(off)*DATA_W +: DATA_W]
                                          : '0;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
    state_nxt         = state;
    bus.busywait      = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_writedata = '0;
    unique case (state)
      IDLE: begin
        // Gated by reset so the stall drops the instant reset is asserted.
        bus.busywait = request && !hit && reset;
        if (request && !hit) begin
          state_nxt = (valid[idx][victim_sel] && dirty[idx][victim_sel]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.busywait      = 1'b1;
        bus.mem_write     = 1'b1;
        bus.mem_address   = {tag_mem[victim_way][idx], idx};
        bus.mem_writedata = data_mem[victim_way][idx];
        if (mem_done) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        bus.busywait    = 1'b1;
        bus.mem_read    = 1'b1;
        bus.mem_address = {tag, idx};
        if (mem_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      victim_way  <= 1'b0;
      first_cycle <= 1'b0;
      retry       <= 1'b0;
      lru         <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= 2'b00;
        dirty[s] <= 2'b00;
      end
    end else begin
      state       <= state_nxt;
      first_cycle <= (state_nxt != state);
      if (state == IDLE) begin
        retry <= 1'b0;
        if (hit) begin
          lru[idx] <= ~hit_way;
          if (bus.write) dirty[idx][hit_way] <= 1'b1;
          if (!retry && hit_count != '1) hit_count <= hit_count + COUNT_W'(1);
        end else if (request) begin
          victim_way <= victim_sel;
          if (miss_count != '1) miss_count <= miss_count + COUNT_W'(1);
        end
      end
      if (state == ALLOCATE && mem_done) begin
        valid[idx][victim_way] <= 1'b1;
        dirty[idx][victim_way] <= 1'b0;
        retry                  <= 1'b1;
      end
    end
  end

  // NOTE: data and tag arrays carry no reset; valid bits alone decide whether their contents matter.
  always_ff @(posedge clock) begin
    if (state == IDLE && hit && bus.write) begin
      data_mem[hit_way][idx][int'(off)*DATA_W +: DATA_W] <= bus.writedata;
    end
    if (state == ALLOCATE && mem_done) begin
      data_mem[victim_way][idx] <= bus.mem_readdata;
      tag_mem[victim_way][idx]  <= tag;
    end
  end
endmodule

// File: tb/tb_dcache_2way_wb.sv
// Self-checking bench for dcache_2way_wb: directed scenarios with literal expectations,
// then random traffic against a transaction-level cache/memory model.
module tb_dcache_2way_wb;
  localparam int CW   = 5;
  localparam int MAXC = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] hit_count, miss_count;

  dcache_2way_wb_if #(.ADDR_W(8), .DATA_W(8), .BLOCK_WORDS(4)) bus ();

  dcache_2way_wb #(.ADDR_W(8), .DATA_W(8), .BLOCK_WORDS(4), .SETS(4), .COUNT_W(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: what the CPU must observe, plus per-set residency in MRU-first order.
  logic [7:0]  golden  [256];
  logic [31:0] mainmem [64];
  int unsigned res_q   [4][$];
  bit          dirty_blk [64];
  int          exp_hits, exp_misses;

  // Expectations for the transaction in flight.
  bit          txn_active = 0;
  int          txn_cycle;
  bit          cur_rd;
  logic [7:0]  cur_addr;
  bit          exp_hit, exp_wb;
  logic [5:0]  exp_fill_blk, exp_wb_blk;
  logic [31:0] exp_wb_data;
  bit          saw_fill, saw_wb;
  logic [5:0]  last_fill_addr, last_wb_addr;
  logic [31:0] last_wb_data;
  logic [7:0]  last_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] golden_block(input int unsigned blk);
    return {golden[blk*4+3], golden[blk*4+2], golden[blk*4+1], golden[blk*4]};
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 4; s++) res_q[s].delete();
    for (int b = 0; b < 64; b++) begin
      dirty_blk[b] = 0;
      for (int w = 0; w < 4; w++) golden[b*4+w] = mainmem[b][w*8 +: 8];
    end
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  function automatic void model_begin(input bit wr, input logic [7:0] a, input logic [7:0] d);
    int unsigned blk = int'(a) >> 2;
    int unsigned s   = blk % 4;
    int          pos = -1;
    for (int i = 0; i < res_q[s].size(); i++) if (res_q[s][i] == blk) pos = i;
    exp_wb       = 0;
    exp_fill_blk = 6'(blk);
    if (pos >= 0) begin
      exp_hit = 1;
      res_q[s].delete(pos);
      if (exp_hits < MAXC) exp_hits++;
    end else begin
      exp_hit = 0;
      if (exp_misses < MAXC) exp_misses++;
      if (res_q[s].size() == 2) begin
        int unsigned victim = res_q[s].pop_back();
        if (dirty_blk[victim]) begin
          exp_wb       = 1;
          exp_wb_blk   = 6'(victim);
          exp_wb_data  = golden_block(victim);
          dirty_blk[victim] = 0;
        end
      end
    end
    res_q[s].push_front(blk);
    if (wr) begin
      golden[a]      = d;
      dirty_blk[blk] = 1;
    end
  endfunction

  // Memory: raises busywait when a request rises, holds it a random number of cycles.
  initial begin
    int cnt = 0;
    bit prev_rd = 0, prev_wr = 0;
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        bus.mem_busywait = 1'b0;
        prev_rd = 0;
        prev_wr = 0;
      end else begin
        if ((bus.mem_read && !prev_rd) || (bus.mem_write && !prev_wr)) begin
          bus.mem_busywait = 1'b1;
          cnt = int'($urandom_range(0, 3));
        end else if ((bus.mem_read || bus.mem_write) && bus.mem_busywait) begin
          if (cnt > 0) cnt--;
          else begin
            bus.mem_busywait = 1'b0;
            if (bus.mem_read)  bus.mem_readdata = mainmem[bus.mem_address];
            if (bus.mem_write) mainmem[bus.mem_address] = bus.mem_writedata;
          end
        end else if (!bus.mem_read && !bus.mem_write) begin
          bus.mem_busywait = 1'b0;
        end
        prev_rd = bus.mem_read;
        prev_wr = bus.mem_write;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the reference.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (!bus.mem_read && !bus.mem_write)
        check("mem_idle_zero", {bus.mem_address, bus.mem_writedata}, '0);
      if (bus.mem_read) begin
        saw_fill       = 1;
        last_fill_addr = bus.mem_address;
        check("fill_expected", 1'b1, txn_active && !exp_hit);
        check("fill_addr", bus.mem_address, exp_fill_blk);
      end
      if (bus.mem_write) begin
        saw_wb       = 1;
        last_wb_addr = bus.mem_address;
        last_wb_data = bus.mem_writedata;
        check("wb_expected", 1'b1, txn_active && exp_wb && !bus.mem_read);
        check("wb_addr", bus.mem_address, exp_wb_blk);
        check("wb_data", bus.mem_writedata, exp_wb_data);
      end
      if (txn_active) begin
        if (txn_cycle == 0) check("first_busywait", bus.busywait, !exp_hit);
        if (!bus.busywait && cur_rd) check("readdata", bus.readdata, golden[cur_addr]);
        txn_cycle++;
      end else begin
        check("idle_busywait", bus.busywait, 1'b0);
        check("idle_readdata", bus.readdata, 8'h00);
      end
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    int budget = 0;
    @(negedge clock);
    bus.read      = rd;
    bus.write     = wr;
    bus.address   = a;
    bus.writedata = d;
    if (rd ^ wr) begin
      model_begin(wr, a, d);
      cur_rd     = rd;
      cur_addr   = a;
      saw_fill   = 0;
      saw_wb     = 0;
      txn_cycle  = 0;
      txn_active = 1;
    end
    #1;
    while (bus.busywait && budget < 200) begin
      @(negedge clock);
      #1;
      budget++;
    end
    check("busywait_timeout", bus.busywait, 1'b0);
    last_rdata = bus.readdata;
    @(negedge clock);
    bus.read   = 1'b0;
    bus.write  = 1'b0;
    txn_active = 0;
    #2;
    if (rd ^ wr) begin
      check("fill_seen", saw_fill, !exp_hit);
      check("wb_seen", saw_wb, exp_wb);
    end
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;
    for (int b = 0; b < 64; b++) mainmem[b] = $urandom;
    mainmem[6'h09] = 32'hDDCCBBAA;
    mainmem[6'h11] = 32'h44332211;
    model_reset();

    repeat (3) @(negedge clock);
    #2;
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    check("rst_busywait", bus.busywait, 1'b0);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    reset = 1'b1;

    // Cold miss, fill, then a counted hit.
    access(1, 0, 8'h25, 8'h00);
    check("t1_fill_addr", last_fill_addr, 6'h09);
    check("t1_rdata", last_rdata, 8'hBB);
    check("t1_miss", miss_count, 1);
    check("t1_hit", hit_count, 0);
    access(1, 0, 8'h25, 8'h00);
    check("t1_rehit", hit_count, 1);

    // Write hit, no memory traffic.
    access(0, 1, 8'h25, 8'h5A);
    check("t2_no_fill", saw_fill, 1'b0);
    access(1, 0, 8'h25, 8'h00);
    check("t2_rdata", last_rdata, 8'h5A);

    // Second way fills from invalid without write-back.
    access(1, 0, 8'h45, 8'h00);
    check("t3_no_wb", saw_wb, 1'b0);
    check("t3_rdata", last_rdata, 8'h22);
    access(1, 0, 8'h25, 8'h00);
    access(1, 0, 8'h45, 8'h00);
    check("t3_hits", hit_count, 5);
    check("t3_misses", miss_count, 2);

    // Dirty LRU victim is written back before the fill.
    access(1, 0, 8'h85, 8'h00);
    check("t4_wb_addr", last_wb_addr, 6'h09);
    check("t4_wb_data", last_wb_data, 32'hDDCC5AAA);
    check("t4_fill_addr", last_fill_addr, 6'h21);
    access(1, 0, 8'h45, 8'h00);
    check("t4_45_hit", hit_count, 6);
    access(1, 0, 8'h25, 8'h00);
    check("t4_25_miss", miss_count, 4);
    check("t4_25_rdata", last_rdata, 8'h5A);

    // Reset in the middle of an allocate.
    @(negedge clock);
    bus.read    = 1'b1;
    bus.address = 8'hC5;
    model_begin(0, 8'hC5, 8'h00);
    cur_rd = 1; cur_addr = 8'hC5; saw_fill = 0; saw_wb = 0; txn_cycle = 0; txn_active = 1;
    budget = 0;
    #1;
    while (!bus.mem_read && budget < 50) begin
      @(negedge clock);
      #1;
      budget++;
    end
    check("t5_alloc_reached", bus.mem_read, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_mem_read_drop", bus.mem_read, 1'b0);
    check("t5_busywait_drop", bus.busywait, 1'b0);
    bus.read   = 1'b0;
    txn_active = 0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    access(1, 0, 8'h25, 8'h00);
    check("t5_post_miss", miss_count, 1);
    check("t5_post_hit", hit_count, 0);

    // read and write together is no request.
    access(1, 1, 8'h25, 8'h77);
    check("t6_hits", hit_count, 0);
    check("t6_misses", miss_count, 1);

    // Random traffic over a few tags per set to mix hits, clean and dirty evictions.
    for (int n = 0; n < 250; n++) begin
      int unsigned kind = $urandom_range(0, 9);
      logic [7:0] a = 8'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
      logic [7:0] d = 8'($urandom);
      if (kind == 0)      access(1, 1, a, d);
      else if (kind == 1) access(0, 0, a, d);
      else if (kind < 5)  access(0, 1, a, d);
      else                access(1, 0, a, d);
    end

    // Counter saturation.
    for (int n = 0; n < 40; n++) access(1, 0, 8'h25, 8'h00);
    check("hit_saturates", hit_count, MAXC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
